// File: rtl/sum4b_display_pkg.sv
// Shared types, widths and the 7-segment decoder for the sum4b display stage.
// The decoder output is active low, ordered g..a (bit 0 = segment a).
package sum4b_disp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_DONE = 2'd2
   } conv_state_t;

   localparam int VAL_W  = 5;
   localparam int BCD_W  = 6;
   localparam int STEPS  = 5;
   localparam int STEP_W = 3;

   localparam logic [6:0] BLANK = 7'b1111111;

   function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
      logic [6:0] seg;
      case (digit)
         4'd0:    seg = 7'b1000000;
         4'd1:    seg = 7'b1111001;
         4'd2:    seg = 7'b0100100;
         4'd3:    seg = 7'b0110000;
         4'd4:    seg = 7'b0011001;
         4'd5:    seg = 7'b0010010;
         4'd6:    seg = 7'b0000010;
         4'd7:    seg = 7'b1111000;
         4'd8:    seg = 7'b0000000;
         4'd9:    seg = 7'b0010000;
         default: seg = BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/sum4b_display_if.sv
// Load/value/status/display bundle between the adder side and the display stage.
interface sum4b_display_if;
   logic       load;
   logic       co;
   logic [3:0] zi;
   logic       busy;
   logic       done;
   logic [1:0] an;
   logic [6:0] sseg;

   modport master (output load, co, zi, input busy, done, an, sseg);
   modport slave  (input load, co, zi, output busy, done, an, sseg);
endinterface

// File: rtl/sum4b_display_bin2bcd5.sv
// Sequential double-dabble: 5-bit binary to tens[1:0]/units[3:0], one step per clock.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | waiting for i_start; operand captured and accumulator cleared
//  ST_CONV | one add-3/shift step per edge, step down-counter to zero
//  ST_DONE | result stable on o_bcd, o_latch high for the digit copy
module bin2bcd5
   import sum4b_disp_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [VAL_W-1:0] i_bin,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_latch,
   output logic [BCD_W-1:0] o_bcd
);

   conv_state_t       r_state;
   conv_state_t       w_next;
   logic [VAL_W-1:0]  r_bin;
   logic [BCD_W-1:0]  r_bcd;
   logic [STEP_W-1:0] r_step;
   logic              r_done;
   logic [3:0]        w_units_adj;
   logic [BCD_W-1:0]  w_bcd_adj;

   // Tens is only two bits wide and can never reach 5, so only units is adjusted.
   assign w_units_adj = (r_bcd[3:0] >= 4'd5) ? (r_bcd[3:0] + 4'd3) : r_bcd[3:0];
   assign w_bcd_adj   = {r_bcd[5:4], w_units_adj};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
         r_bin   <= '0;
         r_bcd   <= '0;
         r_step  <= '0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= (r_state == ST_DONE);
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_bin  <= i_bin;
                  r_bcd  <= '0;
                  r_step <= STEP_W'(STEPS - 1);
               end
            end
            ST_CONV: begin
               {r_bcd, r_bin} <= {w_bcd_adj[BCD_W-2:0], r_bin, 1'b0};
               if (r_step != '0) r_step <= r_step - 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (i_start) w_next = ST_CONV;
         ST_CONV: if (r_step == '0) w_next = ST_DONE;
         ST_DONE: w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   assign o_busy  = (r_state != ST_IDLE);
   assign o_latch = (r_state == ST_DONE);
   assign o_done  = r_done;
   assign o_bcd   = r_bcd;

endmodule

// File: rtl/sum4b_display.sv
// Captures the sum4b result, converts it to BCD and scans it onto a two-digit
// active-low 7-segment display, blanking a zero tens digit.
module sum4b_display
   import sum4b_disp_pkg::*;
#(
   parameter int REFRESH_DIV = 50000
) (
   input  logic          clk,
   input  logic          rst,
   sum4b_display_if.slave bus
);

   localparam int CNT_W = $clog2(REFRESH_DIV);

   logic             w_busy;
   logic             w_done;
   logic             w_latch;
   logic [BCD_W-1:0] w_bcd;

   logic [CNT_W-1:0] r_cnt;
   logic             r_sel;
   logic [3:0]       r_units;
   logic [1:0]       r_tens;
   logic [1:0]       r_an;
   logic [6:0]       r_sseg;

   bin2bcd5 u_conv (
      .clk     (clk),
      .rst     (rst),
      .i_start (bus.load),
      .i_bin   ({bus.co, bus.zi}),
      .o_busy  (w_busy),
      .o_done  (w_done),
      .o_latch (w_latch),
      .o_bcd   (w_bcd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
         r_sel <= 1'b0;
      end else if (r_cnt == CNT_W'(REFRESH_DIV - 1)) begin
         r_cnt <= '0;
         r_sel <= ~r_sel;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_units <= '0;
         r_tens  <= '0;
      end else if (w_latch) begin
         r_units <= w_bcd[3:0];
         r_tens  <= w_bcd[5:4];
      end
   end

   // Registered from the current sel/digits, so a new digit shows one edge after its latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_an   <= 2'b10;
         r_sseg <= seg7_decode(4'd0);
      end else if (!r_sel) begin
         r_an   <= 2'b10;
         r_sseg <= seg7_decode(r_units);
      end else if (r_tens != 2'd0) begin
         r_an   <= 2'b01;
         r_sseg <= seg7_decode({2'b00, r_tens});
      end else begin
         r_an   <= 2'b11;
         r_sseg <= BLANK;
      end
   end

   assign bus.busy = w_busy;
   assign bus.done = w_done;
   assign bus.an   = r_an;
   assign bus.sseg = r_sseg;

endmodule
